prbs_checker: RTL and testbench

//   Serial PRBS receiver/checker, the far end of the two-tap 8-bit LFSR stream generator.

---
 rtl/prbs_pkg.sv | 24 ++
 rtl/prbs_loss_monitor.sv | 46 ++++
 rtl/prbs_checker.sv | 136 +++++++++++++
 tb/tb_prbs_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared PRBS constants, checker state encoding and feedback helper.
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    localparam int PRBS_W      = 8;
    localparam int DEF_TAP_ONE = 2;
    localparam int DEF_TAP_TWO = 4;

    typedef logic [0:0] state_t;
    localparam state_t ST_SEARCH = 1'b0;
    localparam state_t ST_LOCKED = 1'b1;

    // Next generator bit from an 8-bit history, oldest bit at index 0.
    function automatic logic prbs_fb(input logic [PRBS_W-1:0] hist,
                                     input logic [PRBS_W-1:0] tap_mask);
        return ^(hist & tap_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_loss_monitor.sv
`default_nettype none
// ============================================================================
// Module   : prbs_loss_monitor
// Purpose  : Windowed error counter; flags loss of lock when too many errors
//            land in one observation window.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_loss_monitor #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic err,
    input  logic in_lock,
    output logic lose_lock
);

    logic [15:0] r_win_cnt;
    logic [15:0] r_win_err;
    logic [15:0] w_err_next;
    logic        w_win_end;

    assign w_err_next = r_win_err + {15'd0, err};
    assign w_win_end  = (r_win_cnt == 16'(WINDOW - 1));
    // The current bit's error already counts towards the threshold.
    assign lose_lock  = valid && in_lock && (w_err_next >= 16'(LOSS_THRESH));

    always_ff @(posedge clock) begin
        if (reset || !in_lock) begin
            r_win_cnt <= 16'd0;
            r_win_err <= 16'd0;
        end else if (valid) begin
            if (lose_lock || w_win_end) begin
                r_win_cnt <= 16'd0;
                r_win_err <= 16'd0;
            end else begin
                r_win_cnt <= r_win_cnt + 16'd1;
                r_win_err <= w_err_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Purpose  : Self-synchronising serial PRBS checker with lock detection and
//            error counting. Define PRBS_CHK_BITCNT_EN to build bit_count.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int TAP_ONE     = DEF_TAP_ONE,
    parameter int TAP_TWO     = DEF_TAP_TWO,
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_count,
    output logic             locked,
    output logic             error_pulse,
    output logic [ERR_W-1:0] error_count,
    output logic [31:0]      bit_count
);

    localparam logic [PRBS_W-1:0] c_tap_mask = PRBS_W'(1)
                                             | (PRBS_W'(1) << TAP_ONE)
                                             | (PRBS_W'(1) << TAP_TWO);

    state_t             r_state;
    logic [PRBS_W-1:0]  r_hist;
    logic [3:0]         r_fill_cnt;
    logic [7:0]         r_match_cnt;
    logic               r_err_pulse;
    logic [ERR_W-1:0]   r_err_cnt;

    logic w_expected;
    logic w_mismatch;
    logic w_chk_valid;
    logic w_err;
    logic w_lose_lock;

    assign w_expected  = prbs_fb(r_hist, c_tap_mask);
    assign w_mismatch  = (bit_in != w_expected);
    assign w_chk_valid = bit_valid && (r_state == ST_LOCKED);
    assign w_err       = w_chk_valid && w_mismatch;

    prbs_loss_monitor #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_loss (
        .clock     (clock),
        .reset     (reset),
        .valid     (bit_valid),
        .err       (w_err),
        .in_lock   (r_state == ST_LOCKED),
        .lose_lock (w_lose_lock)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_hist      <= '0;
            r_fill_cnt  <= 4'd0;
            r_match_cnt <= 8'd0;
        end else if (bit_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    r_hist <= {bit_in, r_hist[PRBS_W-1:1]};
                    if (r_fill_cnt != 4'(PRBS_W)) begin
                        r_fill_cnt <= r_fill_cnt + 4'd1;
                    end else if (!w_mismatch && (r_hist != '0)) begin
                        if (r_match_cnt == 8'(LOCK_COUNT - 1)) begin
                            r_state     <= ST_LOCKED;
                            r_match_cnt <= 8'd0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                        end
                    end else begin
                        r_match_cnt <= 8'd0;
                    end
                end
                default: begin
                    // Free-run on the local sequence so a flipped bit is one error only.
                    r_hist <= {w_expected, r_hist[PRBS_W-1:1]};
                    if (w_lose_lock) begin
                        r_state     <= ST_SEARCH;
                        r_fill_cnt  <= 4'd0;
                        r_match_cnt <= 8'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear_count) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] r_bit_cnt;

    always_ff @(posedge clock) begin
        if (reset || clear_count) begin
            r_bit_cnt <= 32'd0;
        end else if (w_chk_valid && (r_bit_cnt != 32'hFFFF_FFFF)) begin
            r_bit_cnt <= r_bit_cnt + 32'd1;
        end
    end

    assign bit_count = r_bit_cnt;
`else
    assign bit_count = 32'd0;
`endif

    assign locked      = (r_state == ST_LOCKED);
    assign error_pulse = r_err_pulse;
    assign error_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_checker
// Purpose  : Scoreboard bench for prbs_checker (default and 4-bit counter builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

    logic clock       = 1'b0;
    logic reset       = 1'b1;
    logic bit_in      = 1'b0;
    logic bit_valid   = 1'b0;
    logic clear_count = 1'b0;

    logic        locked_a, error_pulse_a;
    logic [15:0] error_count_a;
    logic [31:0] bit_count_a;
    logic        locked_b, error_pulse_b;
    logic [3:0]  error_count_b;
    logic [31:0] bit_count_b;

    prbs_checker dut_a (
        .clock       (clock),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clear_count (clear_count),
        .locked      (locked_a),
        .error_pulse (error_pulse_a),
        .error_count (error_count_a),
        .bit_count   (bit_count_a)
    );

    prbs_checker #(.ERR_W(4)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clear_count (clear_count),
        .locked      (locked_b),
        .error_pulse (error_pulse_b),
        .error_count (error_count_b),
        .bit_count   (bit_count_b)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int   cyc;
        logic lk;
        logic ep;
        int   eca;
        int   ecb;
        int   bc;
    } snap_t;

    snap_t snap_q[$];
    string name_q[$];
    int    pulse_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 1'b0;
    logic [7:0] gen = 8'h01;

    // Reference transmitter: emits gen[0], feedback from taps 0/2/4.
    task automatic step(input logic b, input logic v, input logic clr);
        bit_in      = b;
        bit_valid   = v;
        clear_count = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic flip, input logic clr);
        if (flip) pulse_q.push_back(edge_n + 1);
        step(gen[0] ^ flip, 1'b1, clr);
        gen = {gen[0] ^ gen[2] ^ gen[4], gen[7:1]};
    endtask

    task automatic chk_state(input string nm, input logic lk, input logic ep,
                             input int eca, input int ecb, input int bc);
        snap_t s;
        s.cyc = edge_n;
        s.lk  = lk;
        s.ep  = ep;
        s.eca = eca;
        s.ecb = ecb;
`ifdef PRBS_CHK_BITCNT_EN
        s.bc  = bc;
`else
        s.bc  = 0;
`endif
        snap_q.push_back(s);
        name_q.push_back(nm);
    endtask

    always @(negedge clock) begin
        snap_t s;
        string nm;
        int    pc;
        if (!done) begin
            while (pulse_q.size() > 0 && pulse_q[0] < edge_n) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse_missing: no error_pulse seen, required at cycle %0d", pulse_q[0]);
                void'(pulse_q.pop_front());
            end
            if (error_pulse_a || error_pulse_b) begin
                n_cmp++;
                if (pulse_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pulse_unexpected: pulse a=%0b b=%0b at cycle %0d, required none",
                             error_pulse_a, error_pulse_b, edge_n);
                end else begin
                    pc = pulse_q.pop_front();
                    if (pc != edge_n || !error_pulse_a || !error_pulse_b) begin
                        n_bad++;
                        $display("FAIL pulse_timing: pulse a=%0b b=%0b at cycle %0d, required both at cycle %0d",
                                 error_pulse_a, error_pulse_b, edge_n, pc);
                    end
                end
            end
            while (snap_q.size() > 0 && snap_q[0].cyc <= edge_n) begin
                s  = snap_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (locked_a !== s.lk || locked_b !== s.lk ||
                    error_pulse_a !== s.ep || error_pulse_b !== s.ep ||
                    int'(error_count_a) != s.eca || int'(error_count_b) != s.ecb ||
                    bit_count_a !== 32'(s.bc) || bit_count_b !== 32'(s.bc)) begin
                    n_bad++;
                    $display("FAIL %s: got locked=%0b/%0b pulse=%0b/%0b cnt=%0d/%0d bits=%0d/%0d, want locked=%0b pulse=%0b cnt=%0d/%0d bits=%0d",
                             nm, locked_a, locked_b, error_pulse_a, error_pulse_b,
                             error_count_a, error_count_b, bit_count_a, bit_count_b,
                             s.lk, s.ep, s.eca, s.ecb, s.bc);
                end
            end
        end
    end

    initial begin
        int nv;

        // Reset held three cycles
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk_state("reset", 1'b0, 1'b0, 0, 0, 0);
        reset = 1'b0;

        // Clean acquisition: 8 fill bits + 16 matches
        repeat (23) send(1'b0, 1'b0);
        chk_state("pre_lock_23", 1'b0, 1'b0, 0, 0, 0);
        send(1'b0, 1'b0);
        chk_state("lock_24", 1'b1, 1'b0, 0, 0, 0);
        repeat (1000) send(1'b0, 1'b0);
        chk_state("clean_1000", 1'b1, 1'b0, 0, 0, 1000);

        // Single flipped bit
        send(1'b1, 1'b0);
        chk_state("one_flip", 1'b1, 1'b1, 1, 1, 1001);
        send(1'b0, 1'b0);
        chk_state("after_flip", 1'b1, 1'b0, 1, 1, 1002);

        // Invalid cycles change nothing; pulse drops after a gap
        step(!gen[0], 1'b0, 1'b0);
        chk_state("gap_no_change", 1'b1, 1'b0, 1, 1, 1002);
        send(1'b1, 1'b0);
        chk_state("flip_two", 1'b1, 1'b1, 2, 2, 1003);
        step(gen[0], 1'b0, 1'b0);
        chk_state("pulse_after_gap", 1'b1, 1'b0, 2, 2, 1003);

        // Mid-stream reset, reacquire, then 8 errors in one window
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_state("mid_reset", 1'b0, 1'b0, 0, 0, 0);
        repeat (23) send(1'b0, 1'b0);
        chk_state("relock_pre", 1'b0, 1'b0, 0, 0, 0);
        send(1'b0, 1'b0);
        chk_state("relock", 1'b1, 1'b0, 0, 0, 0);
        repeat (7) send(1'b1, 1'b0);
        chk_state("seven_errors", 1'b1, 1'b1, 7, 7, 7);
        send(1'b1, 1'b0);
        chk_state("eighth_error_drop", 1'b0, 1'b1, 8, 8, 8);
        repeat (23) send(1'b0, 1'b0);
        chk_state("reacq_pre", 1'b0, 1'b0, 8, 8, 8);
        send(1'b0, 1'b0);
        chk_state("reacq", 1'b1, 1'b0, 8, 8, 8);

        // Sparse errors under threshold: 4-bit counter saturates
        for (int i = 0; i < 200; i++) send((i % 10) == 4, 1'b0);
        chk_state("saturate", 1'b1, 1'b0, 28, 15, 208);
        send(1'b1, 1'b1);
        chk_state("clear_on_error", 1'b1, 1'b1, 0, 0, 0);
        send(1'b0, 1'b0);
        chk_state("after_clear", 1'b1, 1'b0, 0, 0, 1);

        // All-zero stream never locks
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if ((i % 100) == 99) chk_state("zeros_no_lock", 1'b0, 1'b0, 0, 0, 0);
        end

        // 50% valid duty on a clean stream
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 400 && nv < 23; c++) begin
            if ($urandom_range(0, 1) != 0) begin
                send(1'b0, 1'b0);
                nv++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        repeat (5) step(!gen[0], 1'b0, 1'b0);
        chk_state("duty_pre_lock", 1'b0, 1'b0, 0, 0, 0);
        send(1'b0, 1'b0);
        chk_state("duty_lock", 1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_state("duty_hold", 1'b1, 1'b0, 0, 0, 0);

        repeat (4) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (pulse_q.size() != 0 || snap_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d pulses and %0d snapshots left, required 0 and 0",
                     pulse_q.size(), snap_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
